// File: rtl/down_counter_reload.sv
// down_counter_reload
//   Loadable down counter / programmable period timer. A load captures
//   load_val into both the count and a reload register. In RUN the count
//   decrements on enabled cycles. When the count steps off 1 it either
//   stops at 0 (one-shot, state DONE) or re-arms from the reload register
//   (auto-reload). In both cases tc pulses in the cycle the new value
//   appears.
//
// Ports
//   clk      : clock, rising edge
//   res      : asynchronous active-low reset
//   en       : count enable (meaningful only in RUN)
//   load     : load strobe, highest priority
//   load_val : value captured on load
//   mode     : 0 = one-shot, 1 = auto-reload
//   count    : registered counter value
//   tc       : registered terminal-count pulse
//   busy     : state == RUN
//   done     : state == DONE
module down_counter_reload #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             res,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             mode,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state, state_nxt;
  logic [WIDTH-1:0] reload, reload_nxt;
  logic [WIDTH-1:0] count_nxt;
  logic             tc_nxt;

  // State register, together with the datapath registers that share its timing.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state  <= IDLE;
      count  <= '0;
      reload <= '0;
      tc     <= 1'b0;
    end else begin
      state  <= state_nxt;
      count  <= count_nxt;
      reload <= reload_nxt;
      tc     <= tc_nxt;
    end
  end

  // Next-state and datapath logic
  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    reload_nxt = reload;
    tc_nxt     = 1'b0;

    if (load) begin
      count_nxt  = load_val;
      reload_nxt = load_val;
      state_nxt  = (load_val != '0) ? RUN : IDLE;
    end else if (state == RUN && en) begin
      if (count == ONE) begin
        tc_nxt = 1'b1;
        if (mode) begin
          count_nxt = reload;
        end else begin
          count_nxt = '0;
          state_nxt = DONE;
        end
      end else if (count != '0) begin
        // The zero guard keeps the counter from wrapping, even if RUN were
        // somehow entered with a zero count.
        count_nxt = count - ONE;
      end
    end
  end

  // Output decode from the registered state only
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_down_counter_reload.sv
module tb_down_counter_reload;

  localparam int W = 3;

  logic         clk = 1'b0;
  logic         res = 1'b0;
  logic         en = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic         mode = 1'b0;
  logic [W-1:0] count;
  logic         tc, busy, done;

  int checks = 0;
  int failures = 0;

  down_counter_reload #(.WIDTH(W)) dut (
    .clk(clk), .res(res), .en(en), .load(load), .load_val(load_val),
    .mode(mode), .count(count), .tc(tc), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Behavioural reference. phase: 0 = not armed, 1 = counting, 2 = one-shot expired.
  // Plain integer arithmetic is used, so any wrap below zero would show as a mismatch.
  int m_count = 0;
  int m_reload = 0;
  int m_phase = 0;
  int m_tc = 0;

  always @(posedge clk or negedge res) begin
    if (!res) begin
      m_count = 0; m_reload = 0; m_phase = 0; m_tc = 0;
    end else begin
      m_tc = 0;
      if (load) begin
        m_count  = int'(load_val);
        m_reload = int'(load_val);
        m_phase  = (load_val == 0) ? 0 : 1;
      end else if (m_phase == 1 && en) begin
        if (m_count == 1) begin
          m_tc = 1;
          if (mode) m_count = m_reload;
          else begin m_count = 0; m_phase = 2; end
        end else begin
          m_count = m_count - 1;
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    chk("model_count", int'(count), m_count);
    chk("model_tc", int'(tc), m_tc);
    chk("model_busy", int'(busy), (m_phase == 1) ? 1 : 0);
    chk("model_done", int'(done), (m_phase == 2) ? 1 : 0);
  end

  // Drive inputs, take one edge, settle 1 time unit
  task automatic cyc(input logic l, input int lv, input logic e, input logic m);
    load = l; load_val = W'(lv); en = e; mode = m;
    @(posedge clk); #1;
  endtask

  task automatic lit(input string name, input int c, input int t, input int b, input int d);
    chk({name, "_count"}, int'(count), c);
    chk({name, "_tc"}, int'(tc), t);
    chk({name, "_busy"}, int'(busy), b);
    chk({name, "_done"}, int'(done), d);
  endtask

  initial begin
    int exp_ar [9];
    int en_seq [5];
    int exp_en [5];
    exp_ar = '{3, 2, 1, 4, 3, 2, 1, 4, 3};
    en_seq = '{1, 0, 0, 1, 1};
    exp_en = '{4, 4, 4, 3, 2};

    // Power-on reset
    #12;
    lit("por", 0, 0, 0, 0);
    @(posedge clk); #1; res = 1'b1;

    // Asynchronous reset mid-count
    cyc(1, 5, 0, 0);
    lit("pre_reset", 5, 0, 1, 0);
    #2 res = 1'b0;
    #1 lit("async_reset", 0, 0, 0, 0);
    @(posedge clk); #1;
    lit("reset_hold", 0, 0, 0, 0);
    res = 1'b1;
    cyc(0, 0, 1, 0);
    lit("after_release", 0, 0, 0, 0);

    // One-shot 3,2,1,0
    cyc(1, 3, 0, 0); lit("os_load", 3, 0, 1, 0);
    cyc(0, 0, 1, 0); lit("os_2", 2, 0, 1, 0);
    cyc(0, 0, 1, 0); lit("os_1", 1, 0, 1, 0);
    cyc(0, 0, 1, 0); lit("os_0", 0, 1, 0, 1);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 1, 0); lit("os_hold", 0, 0, 0, 1);
    end

    // Auto-reload period 4
    cyc(1, 4, 0, 1); lit("ar_load", 4, 0, 1, 0);
    for (int i = 0; i < 9; i++) begin
      cyc(0, 0, 1, 1);
      lit("ar_seq", exp_ar[i], (exp_ar[i] == 4) ? 1 : 0, 1, 0);
    end

    // Enable gating
    cyc(1, 5, 0, 0); lit("eg_load", 5, 0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, logic'(en_seq[i]), 0); lit("eg_seq", exp_en[i], 0, 1, 0);
    end

    // Load colliding with terminal cycle
    cyc(1, 2, 0, 0);
    cyc(0, 0, 1, 0); lit("col_pre", 1, 0, 1, 0);
    cyc(1, 6, 1, 0); lit("col", 6, 0, 1, 0);

    // Load of zero
    cyc(1, 0, 1, 0); lit("zero_load", 0, 0, 0, 0);
    cyc(0, 0, 1, 1); lit("zero_hold", 0, 0, 0, 0);

    // Maximum value counts fully down without wrap
    cyc(1, 7, 0, 0); lit("max_load", 7, 0, 1, 0);
    for (int i = 6; i >= 0; i--) begin
      cyc(0, 0, 1, 0); lit("max_seq", i, (i == 0) ? 1 : 0, (i == 0) ? 0 : 1, (i == 0) ? 1 : 0);
    end
    cyc(0, 0, 1, 0); lit("max_nowrap", 0, 0, 0, 1);

    // Reload value 1: tc every enabled cycle, then one-shot exit
    cyc(1, 1, 0, 1); lit("r1_load", 1, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 1, 1); lit("r1_tc", 1, 1, 1, 0);
    end
    cyc(0, 0, 1, 0); lit("r1_exit", 0, 1, 0, 1);
    cyc(0, 0, 1, 0); lit("r1_after", 0, 0, 0, 1);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      cyc(logic'($urandom_range(0, 9) == 0), int'($urandom_range(0, 7)),
          logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 1)));
      if ($urandom_range(0, 199) == 0) begin
        #2 res = 1'b0;
        #3 res = 1'b1;
      end
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/down_counter_reload.md
Name: down_counter_reload

Overview:
- Synchronous loadable down counter; the count-down counterpart of the team's gate-level up counter.
- Counts from a loaded value toward zero and emits a one-cycle terminal-count pulse.
- Two modes: one-shot (stops at zero) or auto-reload (periodic tick generator).
- Used as a programmable delay/period timer next to the up counters in the same counter library.

Parameters:
WIDTH, 3, bit width of count, load_val and internal reload register (legal range 2..16)

Ports:
clk  input  1  clock; all state changes on rising edge
res  input  1  reset, asynchronous, active-low (res=0 clears immediately)
en  input  1  count enable; decrement only in cycles with en=1
load  input  1  load strobe; captures load_val into count and reload register
load_val  input  WIDTH  value to load
mode  input  1  0 = one-shot, 1 = auto-reload
count  output  WIDTH  current counter value (registered)
tc  output  1  terminal-count pulse, registered, high exactly one cycle
busy  output  1  high while state = RUN
done  output  1  high while state = DONE

Behaviour:
- Reset (res=0, asynchronous, no clock needed): count=0, reload register=0, state=IDLE, tc=0, busy=0, done=0. Outputs stay there while res=0. First active edge after release behaves as IDLE.
- States:
  - IDLE: counter not armed.
  - RUN: counting.
  - DONE: one-shot expired.
  - busy and done are decoded from registered state, with no combinational path from inputs.
- Load (highest priority in any state, en ignored that cycle):
  - Next count = load_val; reload register = load_val; tc=0.
  - load_val != 0: next state RUN.
  - load_val == 0: next state IDLE, no tc.
- RUN, en=1, load=0:
  - count > 1: count <= count-1, tc=0.
  - count == 1, mode=0: count <= 0, state <= DONE, tc=1 for that one cycle.
  - count == 1, mode=1: count <= reload register, stay RUN, tc=1 for one cycle.
  - Period in auto-reload = reload value in enabled cycles.
- RUN, en=0, load=0: count and state hold, tc=0. Mode changes while counting take effect only at the count==1 decision.
- IDLE / DONE, load=0: count holds (0 in DONE), tc=0. en has no effect, and the counter never wraps from 0 to 2^WIDTH-1.
- tc is asserted in the cycle where the new count (0 or reload) first appears, and is never asserted two consecutive cycles except in auto-reload with reload value 1. In that case tc stays high every enabled cycle, which is required behaviour.
- Load coinciding with terminal cycle (count==1, en=1, load=1): load wins, count=load_val, tc=0.
- Maximum load value 2^WIDTH-1 counts down fully with no overflow. Arithmetic is WIDTH bits unsigned. The decrement is never applied at count=0.
- Reset asserted mid-count: immediate clear per reset rule; the reload register is also lost.

Test Plan:
- Reset check: res=0 asynchronously mid-cycle with count=5 in RUN -> count=0, tc=0, busy=0, done=0 before the next clk edge. Same values held after release.
- One-shot: load_val=3, mode=0, load one cycle, then en=1 -> count 3,2,1,0. tc=1 only in the cycle count becomes 0. busy=1 during 3..1, then done=1, count stays 0 for 5 more enabled cycles.
- Auto-reload: load_val=4, mode=1, en=1 continuous -> count 4,3,2,1,4,3,2,1,4... with tc high on each return to 4 (every 4 cycles) and busy stays 1.
- Enable gating: load_val=5, en toggling 1,0,0,1,1 -> count 5,4,4,4,3,2 and tc=0 throughout.
- Collision and edge values:
  - load=1 with load_val=6 in the cycle count==1, en=1 -> count=6, tc=0.
  - load_val=0 -> IDLE, count=0, no tc.
  - load_val=7 (WIDTH=3) -> 7 down to 0, no wrap.
- Reload value 1: load_val=1, mode=1, en=1 -> count stays 1, tc=1 every cycle. Switching mode to 0 -> next enabled cycle count=0, done=1, tc single final pulse.
